// File: rtl/multi_config_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_config_counter_pkg
// Description : Shared types, default constants and sizing helpers for the
//               multi-lane credit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package multi_config_counter_pkg;

  localparam int unsigned DEF_COUNT_SZ = 10;
  localparam int unsigned DEF_MAX_VAL  = (1 << DEF_COUNT_SZ) - 1;

  typedef logic [DEF_COUNT_SZ-1:0] count_t;

  // Lane-select width; a single-lane build still gets a 1-bit select.
  function automatic int unsigned lane_sel_w(input int unsigned nch);
    return (nch > 1) ? unsigned'($clog2(nch)) : 1;
  endfunction

  function automatic int unsigned max_val_of(input int unsigned sz);
    return (1 << sz) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_config_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_config_counter_if
// Description : Strobe/config/read bundle shared between a credit-counter
//               block (slave) and its driver (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_config_counter_if
  import multi_config_counter_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned COUNT_SZ = DEF_COUNT_SZ
);
  localparam int unsigned SEL_W = lane_sel_w(NCH);

  logic [NCH-1:0]          increment__ENA;
  logic [NCH*COUNT_SZ-1:0] increment_v;
  logic [NCH-1:0]          decrement__ENA;
  logic [NCH*COUNT_SZ-1:0] decrement_v;
  logic [NCH-1:0]          decrement__RDY;
  logic [NCH-1:0]          maybeDecrement__ENA;
  logic [NCH*COUNT_SZ-1:0] maybeDecrement_v;
  logic [NCH-1:0]          maybeDecrement;
  logic                    cfg__ENA;
  logic [SEL_W-1:0]        cfg_ch;
  logic [COUNT_SZ-1:0]     cfg_thresh;
  logic [NCH-1:0]          clear__ENA;
  logic [SEL_W-1:0]        read_sel;
  logic [COUNT_SZ-1:0]     read;
  logic [NCH-1:0]          positive;
  logic [NCH-1:0]          above;
  logic [NCH-1:0]          err;

  modport slave (
    input  increment__ENA, increment_v, decrement__ENA, decrement_v,
           maybeDecrement__ENA, maybeDecrement_v, cfg__ENA, cfg_ch,
           cfg_thresh, clear__ENA, read_sel,
    output decrement__RDY, maybeDecrement, read, positive, above, err
  );

  modport master (
    output increment__ENA, increment_v, decrement__ENA, decrement_v,
           maybeDecrement__ENA, maybeDecrement_v, cfg__ENA, cfg_ch,
           cfg_thresh, clear__ENA, read_sel,
    input  decrement__RDY, maybeDecrement, read, positive, above, err
  );

endinterface
`default_nettype wire

// File: rtl/multi_config_counter_lane.sv
`default_nettype none
// ============================================================================
// Module      : config_counter_lane
// Description : One saturating credit counter with threshold register and
//               registered flags. Sticky error logic under
//               MULTI_CONFIG_COUNTER_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module config_counter_lane
  import multi_config_counter_pkg::*;
#(
  parameter int unsigned COUNT_SZ = DEF_COUNT_SZ,
  parameter int unsigned INIT_VAL = 0,
  parameter int unsigned MAX_VAL  = max_val_of(COUNT_SZ)
) (
  input  wire logic                CLK,
  input  wire logic                nRST,
  input  wire logic                inc_ena,
  input  wire logic [COUNT_SZ-1:0] inc_v,
  input  wire logic                dec_ena,
  input  wire logic [COUNT_SZ-1:0] dec_v,
  output logic                     dec_rdy,
  input  wire logic                maybe_ena,
  input  wire logic [COUNT_SZ-1:0] maybe_v,
  output logic                     maybe_taken,
  input  wire logic                cfg_we,
  input  wire logic [COUNT_SZ-1:0] cfg_thresh,
  input  wire logic                clear,
  output logic [COUNT_SZ-1:0]      cnt,
  output logic                     positive,
  output logic                     above,
  output logic                     err
);

  localparam logic [COUNT_SZ-1:0] c_init    = COUNT_SZ'(INIT_VAL);
  localparam logic [COUNT_SZ-1:0] c_max     = COUNT_SZ'(MAX_VAL);
  localparam logic [COUNT_SZ:0]   c_max_ext = (COUNT_SZ+1)'(MAX_VAL);

  logic [COUNT_SZ-1:0] r_cnt;
  logic [COUNT_SZ-1:0] r_thresh;
  logic                r_positive;
  logic                r_above;

  logic [COUNT_SZ:0]   w_inc_ext;
  logic [COUNT_SZ:0]   w_dec_ext;
  logic [COUNT_SZ:0]   w_sum;
  logic                w_sat;
  logic                w_illegal;
  logic [COUNT_SZ-1:0] w_next;

  assign dec_rdy     = (r_cnt >= dec_v);
  // A guarded decrement strobe blocks the maybe path even when it is refused.
  assign maybe_taken = maybe_ena && !dec_ena && (r_cnt >= maybe_v);
  assign w_illegal   = dec_ena && !dec_rdy;

  always_comb begin
    w_inc_ext = '0;
    w_dec_ext = '0;
    if (inc_ena)              w_inc_ext = {1'b0, inc_v};
    if (dec_ena && dec_rdy)   w_dec_ext = {1'b0, dec_v};
    else if (maybe_taken)     w_dec_ext = {1'b0, maybe_v};
    // Extra bit holds cnt+inc; subtraction cannot underflow since dec<=cnt.
    w_sum = {1'b0, r_cnt} + w_inc_ext - w_dec_ext;
    w_sat = (w_sum > c_max_ext);
    if (clear)      w_next = c_init;
    else if (w_sat) w_next = c_max;
    else            w_next = w_sum[COUNT_SZ-1:0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt      <= c_init;
      r_thresh   <= c_max;
      r_positive <= (INIT_VAL > 0);
      r_above    <= (INIT_VAL == MAX_VAL);
    end else begin
      r_cnt      <= w_next;
      r_positive <= (w_next != '0);
      // Flags use the threshold in force this cycle, not one being written.
      r_above    <= (w_next >= r_thresh);
      if (cfg_we) r_thresh <= cfg_thresh;
    end
  end

`ifdef MULTI_CONFIG_COUNTER_ERR_EN
  logic r_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     r_err <= 1'b0;
    else if (clear)                r_err <= 1'b0;
    else if (w_sat || w_illegal)   r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign cnt      = r_cnt;
  assign positive = r_positive;
  assign above    = r_above;

endmodule
`default_nettype wire

// File: rtl/multi_config_counter.sv
`default_nettype none
// ============================================================================
// Module      : multi_config_counter
// Description : NCH independent credit counters with a shared config/read
//               port. Optional sticky errors: MULTI_CONFIG_COUNTER_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_config_counter
  import multi_config_counter_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned COUNT_SZ = DEF_COUNT_SZ,
  parameter int unsigned INIT_VAL = 0,
  parameter int unsigned MAX_VAL  = max_val_of(COUNT_SZ)
) (
  input  wire logic             CLK,
  input  wire logic             nRST,
  multi_config_counter_if.slave bus
);

  localparam int unsigned SEL_W = lane_sel_w(NCH);

  logic [COUNT_SZ-1:0] w_cnt [NCH];
  logic [NCH-1:0]      w_cfg_we;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    localparam logic [SEL_W-1:0] c_idx = SEL_W'(i);

    // Out-of-range lane selects never match any lane and are dropped.
    assign w_cfg_we[i] = bus.cfg__ENA && (bus.cfg_ch == c_idx);

    config_counter_lane #(
      .COUNT_SZ (COUNT_SZ),
      .INIT_VAL (INIT_VAL),
      .MAX_VAL  (MAX_VAL)
    ) u_lane (
      .CLK         (CLK),
      .nRST        (nRST),
      .inc_ena     (bus.increment__ENA[i]),
      .inc_v       (bus.increment_v[i*COUNT_SZ +: COUNT_SZ]),
      .dec_ena     (bus.decrement__ENA[i]),
      .dec_v       (bus.decrement_v[i*COUNT_SZ +: COUNT_SZ]),
      .dec_rdy     (bus.decrement__RDY[i]),
      .maybe_ena   (bus.maybeDecrement__ENA[i]),
      .maybe_v     (bus.maybeDecrement_v[i*COUNT_SZ +: COUNT_SZ]),
      .maybe_taken (bus.maybeDecrement[i]),
      .cfg_we      (w_cfg_we[i]),
      .cfg_thresh  (bus.cfg_thresh),
      .clear       (bus.clear__ENA[i]),
      .cnt         (w_cnt[i]),
      .positive    (bus.positive[i]),
      .above       (bus.above[i]),
      .err         (bus.err[i])
    );
  end

  always_comb begin
    bus.read = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.read_sel == SEL_W'(i)) bus.read = w_cnt[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_config_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_config_counter
// Description : Directed self-checking bench for multi_config_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_config_counter;

`ifdef MULTI_CONFIG_COUNTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int W = 10;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  multi_config_counter_if #(.NCH(4), .COUNT_SZ(W)) bus ();

  multi_config_counter #(
    .NCH      (4),
    .COUNT_SZ (W),
    .INIT_VAL (0),
    .MAX_VAL  (1023)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.increment__ENA      = '0;
    bus.increment_v         = '0;
    bus.decrement__ENA      = '0;
    bus.decrement_v         = '0;
    bus.maybeDecrement__ENA = '0;
    bus.maybeDecrement_v    = '0;
    bus.cfg__ENA            = 1'b0;
    bus.cfg_ch              = '0;
    bus.cfg_thresh          = '0;
    bus.clear__ENA          = '0;
    bus.read_sel            = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      bus.read_sel = i[1:0];
      #1;
      total++;
      if (bus.read !== 10'd0) begin
        bad++;
        $display("FAIL reset_read lane %0d: got %0d want 0", i, bus.read);
      end
    end
    total++;
    if (bus.positive !== 4'b0000 || bus.above !== 4'b0000 || bus.err !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got pos=%b above=%b err=%b want 0000", bus.positive, bus.above, bus.err);
    end
    bus.decrement_v = {4{10'd0}};
    #1;
    total++;
    if (bus.decrement__RDY !== 4'b1111) begin
      bad++;
      $display("FAIL reset_rdy_v0: got %b want 1111", bus.decrement__RDY);
    end
    bus.decrement_v = {4{10'd1}};
    #1;
    total++;
    if (bus.decrement__RDY !== 4'b0000) begin
      bad++;
      $display("FAIL reset_rdy_v1: got %b want 0000", bus.decrement__RDY);
    end
    bus.decrement_v = '0;
  endtask

  task automatic test_inc_dec();
    bus.read_sel = 2'd0;
    bus.increment__ENA[0] = 1'b1;
    bus.increment_v[0 +: W] = 10'd5;
    step();
    idle();
    #1;
    total++;
    if (bus.read !== 10'd5 || bus.positive[0] !== 1'b1) begin
      bad++;
      $display("FAIL inc5: got read=%0d pos=%b want 5/1", bus.read, bus.positive[0]);
    end
    bus.increment__ENA[0] = 1'b1;
    bus.increment_v[0 +: W] = 10'd2;
    bus.decrement__ENA[0] = 1'b1;
    bus.decrement_v[0 +: W] = 10'd3;
    #1;
    total++;
    if (bus.decrement__RDY[0] !== 1'b1) begin
      bad++;
      $display("FAIL dec3_rdy: got %b want 1", bus.decrement__RDY[0]);
    end
    step();
    idle();
    #1;
    total++;
    if (bus.read !== 10'd4) begin
      bad++;
      $display("FAIL inc2_dec3: got %0d want 4", bus.read);
    end
  endtask

  task automatic test_maybe();
    bus.increment__ENA[1] = 1'b1;
    bus.increment_v[W +: W] = 10'd4;
    step();
    idle();
    bus.read_sel = 2'd1;
    bus.decrement__ENA[1] = 1'b1;
    bus.decrement_v[W +: W] = 10'd2;
    bus.maybeDecrement__ENA[1] = 1'b1;
    bus.maybeDecrement_v[W +: W] = 10'd1;
    #1;
    total++;
    if (bus.maybeDecrement[1] !== 1'b0 || bus.read !== 10'd4) begin
      bad++;
      $display("FAIL dec_blocks_maybe: got maybe=%b read=%0d want 0/4", bus.maybeDecrement[1], bus.read);
    end
    step();
    bus.decrement__ENA[1] = 1'b0;
    #1;
    total++;
    if (bus.read !== 10'd2 || bus.maybeDecrement[1] !== 1'b1) begin
      bad++;
      $display("FAIL dec2_result: got read=%0d maybe=%b want 2/1", bus.read, bus.maybeDecrement[1]);
    end
    step();
    total++;
    if (bus.read !== 10'd1) begin
      bad++;
      $display("FAIL maybe1_taken: got %0d want 1", bus.read);
    end
    // illegal decrement: refused, and the maybe path is still blocked
    bus.decrement__ENA[1] = 1'b1;
    bus.decrement_v[W +: W] = 10'd5;
    #1;
    total++;
    if (bus.decrement__RDY[1] !== 1'b0 || bus.maybeDecrement[1] !== 1'b0) begin
      bad++;
      $display("FAIL illegal_dec_comb: got rdy=%b maybe=%b want 0/0", bus.decrement__RDY[1], bus.maybeDecrement[1]);
    end
    step();
    idle();
    bus.read_sel = 2'd1;
    bus.maybeDecrement__ENA[1] = 1'b1;
    bus.maybeDecrement_v[W +: W] = 10'd5;
    #1;
    total++;
    if (bus.read !== 10'd1 || bus.err[1] !== ERR_EN || bus.maybeDecrement[1] !== 1'b0) begin
      bad++;
      $display("FAIL illegal_dec_result: got read=%0d err=%b maybe=%b want 1/%b/0", bus.read, bus.err[1], bus.maybeDecrement[1], ERR_EN);
    end
    step();
    idle();
    bus.read_sel = 2'd1;
    #1;
    total++;
    if (bus.read !== 10'd1) begin
      bad++;
      $display("FAIL maybe5_refused: got %0d want 1", bus.read);
    end
  endtask

  task automatic test_saturation();
    bus.read_sel = 2'd2;
    bus.increment__ENA[2] = 1'b1;
    bus.increment_v[2*W +: W] = 10'd1000;
    step();
    total++;
    if (bus.read !== 10'd1000 || bus.err[2] !== 1'b0) begin
      bad++;
      $display("FAIL inc1000: got read=%0d err=%b want 1000/0", bus.read, bus.err[2]);
    end
    bus.increment_v[2*W +: W] = 10'd100;
    step();
    idle();
    bus.read_sel = 2'd2;
    #1;
    total++;
    if (bus.read !== 10'd1023 || bus.err[2] !== ERR_EN || bus.above[2] !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got read=%0d err=%b above=%b want 1023/%b/1", bus.read, bus.err[2], bus.above[2], ERR_EN);
    end
    // clear wins over a simultaneous increment
    bus.clear__ENA[2] = 1'b1;
    bus.increment__ENA[2] = 1'b1;
    bus.increment_v[2*W +: W] = 10'd5;
    step();
    idle();
    bus.read_sel = 2'd2;
    #1;
    total++;
    if (bus.read !== 10'd0 || bus.err[2] !== 1'b0 || bus.positive[2] !== 1'b0 || bus.err[1] !== ERR_EN) begin
      bad++;
      $display("FAIL clear: got read=%0d err=%b pos=%b err1=%b want 0/0/0/%b", bus.read, bus.err[2], bus.positive[2], bus.err[1], ERR_EN);
    end
  endtask

  task automatic test_threshold();
    bus.read_sel = 2'd3;
    bus.cfg__ENA = 1'b1;
    bus.cfg_ch = 2'd3;
    bus.cfg_thresh = 10'd8;
    bus.increment__ENA[3] = 1'b1;
    bus.increment_v[3*W +: W] = 10'd8;
    step();
    idle();
    bus.read_sel = 2'd3;
    #1;
    total++;
    if (bus.read !== 10'd8 || bus.above[3] !== 1'b0) begin
      bad++;
      $display("FAIL cfg_old_thresh: got read=%0d above=%b want 8/0", bus.read, bus.above[3]);
    end
    step();
    total++;
    if (bus.above[3] !== 1'b1) begin
      bad++;
      $display("FAIL above_at_thresh: got %b want 1", bus.above[3]);
    end
    bus.decrement__ENA[3] = 1'b1;
    bus.decrement_v[3*W +: W] = 10'd1;
    step();
    idle();
    bus.read_sel = 2'd3;
    #1;
    total++;
    if (bus.read !== 10'd7 || bus.above[3] !== 1'b0) begin
      bad++;
      $display("FAIL below_thresh: got read=%0d above=%b want 7/0", bus.read, bus.above[3]);
    end
  endtask

  task automatic test_reset_mid();
    bus.read_sel = 2'd0;
    bus.increment__ENA = 4'b1111;
    bus.increment_v = {4{10'd7}};
    #2;
    nRST = 1'b0;
    #1;
    total++;
    if (bus.read !== 10'd0 || bus.positive !== 4'b0000 || bus.above !== 4'b0000 || bus.err !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got read=%0d pos=%b above=%b err=%b want 0/0000/0000/0000", bus.read, bus.positive, bus.above, bus.err);
    end
    step();
    total++;
    if (bus.read !== 10'd0 || bus.positive !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold: got read=%0d pos=%b want 0/0000", bus.read, bus.positive);
    end
    idle();
    #1;
    nRST = 1'b1;
    step();
    total++;
    if (bus.read !== 10'd0 || bus.positive !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release: got read=%0d pos=%b want 0/0000", bus.read, bus.positive);
    end
    // threshold register must be back at the ceiling
    bus.increment__ENA[3] = 1'b1;
    bus.increment_v[3*W +: W] = 10'd8;
    step();
    step();
    idle();
    bus.read_sel = 2'd3;
    #1;
    total++;
    if (bus.read !== 10'd16 || bus.above[3] !== 1'b0) begin
      bad++;
      $display("FAIL thresh_reset: got read=%0d above=%b want 16/0", bus.read, bus.above[3]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    idle();
    #2;
    test_reset();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    test_inc_dec();
    test_maybe();
    test_saturation();
    test_threshold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
